upsizer_rr_arbiter: RTL and testbench
=====================================

Name: upsizer_rr_arbiter

Overview:
Round-robin scheduler that shares one 256→1024 upsizer between NUM_REQ requesters. It grants one requester at a time for a whole BEATS-beat burst, so beats from different sources never mix in one 1024-bit word. It muxes the granted stream onto the upsizer's inp_data/valid_in. A tag FIFO records the owner of each burst, so every upsizer out_en pulse is labelled with its source ID.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IN_W, 256, beat width, equal to the upsizer input width
BEATS, 4, beats per upsizer output word (1024/256)
ID_W, 2, requester ID width, equal to clog2(NUM_REQ)
TAG_DEPTH, 4, tag FIFO depth (power of 2)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous active-low reset; the same net drives the upsizer rstn
req_valid  in  NUM_REQ  per-requester beat valid
req_data  in  NUM_REQ*IN_W  per-requester beat; requester i occupies bits [i*IN_W +: IN_W]
req_ready  out  NUM_REQ  per-requester beat accept
up_inp_data  out  IN_W  to upsizer inp_data
up_valid_in  out  1  to upsizer valid_in
up_out_en  in  1  from upsizer out_en (one pulse per 1024-bit word)
out_id  out  ID_W  owner of the word currently flagged by up_out_en
out_id_valid  out  1  out_id qualifier
grant_id  out  ID_W  currently or last granted requester
busy  out  1  high in BURST state
tag_err  out  1  sticky: up_out_en seen while tag FIFO empty

Behaviour:
- Reset (rstn=0 at a clk edge) forces:
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0, tag_err=0
  - tag FIFO empty, count=0
  - req_ready=0, up_valid_in=0, up_inp_data=0, out_id_valid=0
- Reset mid-burst: the partial burst is discarded with no tag pushed. The upsizer shares rstn, so its partial word is also dropped.
- States: IDLE, BURST.
- IDLE:
  - req_ready=0, up_valid_in=0.
  - If any req_valid=1 and tag count<TAG_DEPTH, select the first asserted index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - At the next edge: grant_id<=selected, beat_cnt<=0, state<=BURST.
  - If tag FIFO is full, stay in IDLE (no grant).
- BURST:
  - busy=1.
  - req_ready[grant_id]=1; all other req_ready bits=0.
  - up_valid_in=req_valid[grant_id] (combinational); up_inp_data=req_data slice for grant_id (combinational).
  - A beat is accepted when req_valid[grant_id]=1.
  - On acceptance with beat_cnt<BEATS-1: beat_cnt++.
  - On acceptance with beat_cnt=BEATS-1:
    - push grant_id into the tag FIFO
    - rr_ptr<=(grant_id+1) mod NUM_REQ
    - state<=IDLE
  - Bubbles (req_valid low mid-burst) hold the grant indefinitely; there is no preemption or timeout.
- Timing: one arbitration bubble per burst. The minimum period is BEATS+1 cycles per 1024-bit word.
- Tag FIFO:
  - Pop on up_out_en=1.
  - out_id=head entry and out_id_valid=up_out_en & (count≠0), both combinational, same cycle as out_en.
  - Push and pop in the same cycle: count unchanged; the head is popped before the new entry becomes visible.
  - up_out_en with count=0: no pop, out_id_valid=0, tag_err<=1 (cleared only by reset).
  - Pointers wrap modulo TAG_DEPTH. The grant gate in IDLE prevents overflow.
- A requester that drops req_valid while in IDLE is simply not granted. Arbitration samples req_valid only in IDLE.

Test Plan:
- Single requester:
  - Stimulus: after reset, req 2 presents beats 0xA0..0xA3 back-to-back.
  - Response: grant_id=2 one cycle after req_valid rises; up_valid_in high for 4 cycles carrying A0..A3 in order; tag push of 2; the later up_out_en gives out_id=2, out_id_valid=1.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold req_valid continuously.
  - Response: grant order 0,1,2,3,0; each burst is 4 beats followed by one IDLE cycle; out_id sequence on successive out_en pulses is 0,1,2,3.
- Mid-burst bubble:
  - Stimulus: req 1 sends 2 beats, drops valid for 3 cycles, then sends 2 more while req 3 is also requesting.
  - Response: grant stays 1 throughout (req_ready[3]=0); up_valid_in low during the gap; the next grant is 3.
- Tag FIFO full:
  - Stimulus: hold up_out_en=0 while 4 bursts complete.
  - Response: tag count=4; with further req_valid asserted, state stays IDLE and busy=0; after one up_out_en pulse, a grant issues the next cycle.
- Reset mid-burst:
  - Stimulus: assert rstn=0 after beat 2 of a req 0 burst.
  - Response: next cycle all outputs at reset values and tag FIFO empty; after release, req 0 is re-granted and its 4 new beats form a complete burst.
- Spurious out_en:
  - Stimulus: pulse up_out_en with the FIFO empty.
  - Response: out_id_valid=0; tag_err=1 and stays 1 until rstn=0.

Source files
------------

// File: rtl/upsizer_rr_arbiter.sv
// Round-robin arbiter sharing one 256->1024 upsizer between NUM_REQ requesters.
// Grants whole BEATS-beat bursts and tags each output word with its owner ID.
module upsizer_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IN_W      = 256,
    parameter int BEATS     = 4,
    parameter int ID_W      = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [NUM_REQ*IN_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic [IN_W-1:0]         o_up_inp_data,
    output logic                    o_up_valid_in,
    input  logic                    i_up_out_en,
    output logic [ID_W-1:0]         o_out_id,
    output logic                    o_out_id_valid,
    output logic [ID_W-1:0]         o_grant_id,
    output logic                    o_busy,
    output logic                    o_tag_err
);
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           r_state, w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr, r_grant_id, w_sel_id;
    logic             w_sel_found;
    logic [BC_W-1:0]  r_beat_cnt;
    logic [ID_W-1:0]  r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_tag_err;
    logic             w_full, w_empty, w_grant, w_accept, w_last, w_pop;

    assign w_full  = (r_count == CNT_W'(TAG_DEPTH));
    assign w_empty = (r_count == '0);

    // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int idx;
        idx         = 0;
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_sel_found && i_req_valid[idx]) begin
                w_sel_found = 1'b1;
                w_sel_id    = ID_W'(idx);
            end
        end
    end

    assign w_grant  = (r_state == IDLE) && w_sel_found && !w_full;
    assign w_accept = (r_state == BURST) && i_req_valid[r_grant_id];
    assign w_last   = w_accept && (r_beat_cnt == BC_W'(BEATS - 1));
    assign w_pop    = i_up_out_en && !w_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_req_ready   = '0;
        o_up_valid_in = 1'b0;
        o_up_inp_data = '0;
        o_busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) w_state_nxt = BURST;
            end
            BURST: begin
                o_busy                  = 1'b1;
                o_req_ready[r_grant_id] = 1'b1;
                o_up_valid_in           = i_req_valid[r_grant_id];
                o_up_inp_data           = i_req_data[r_grant_id*IN_W +: IN_W];
                if (w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tag_err  <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) r_tag_mem[i] <= '0;
        end else begin
            if (w_grant) begin
                r_grant_id <= w_sel_id;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_beat_cnt <= '0;
                    r_rr_ptr   <= (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
            if (w_last) begin
                r_tag_mem[r_wr_ptr] <= r_grant_id;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the occupancy unchanged
            case ({w_last, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_up_out_en && w_empty) r_tag_err <= 1'b1;
        end
    end

    assign o_out_id       = r_tag_mem[r_rd_ptr];
    assign o_out_id_valid = w_pop;
    assign o_grant_id     = r_grant_id;
    assign o_tag_err      = r_tag_err;

endmodule

// File: tb/tb_upsizer_rr_arbiter.sv
// Scoreboard bench for upsizer_rr_arbiter: beat and tag expectations are queued
// by the stimulus and consumed by a negedge monitor.
module tb_upsizer_rr_arbiter;
    localparam int NR = 4;
    localparam int W  = 256;

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] data;
    } beat_t;

    logic            clk, rstn;
    logic [NR-1:0]   req_valid, req_ready;
    logic [NR*W-1:0] req_data;
    logic [W-1:0]    up_inp_data;
    logic            up_valid_in, up_out_en;
    logic [1:0]      out_id, grant_id;
    logic            out_id_valid, busy, tag_err;

    logic [W-1:0] src_q [NR][$];
    beat_t        exp_beat[$];
    logic [1:0]   exp_id[$];
    int           n_checks = 0;
    int           n_errs   = 0;

    upsizer_rr_arbiter #(.NUM_REQ(4), .IN_W(256), .BEATS(4), .ID_W(2), .TAG_DEPTH(4)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_req_valid(req_valid), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_up_inp_data(up_inp_data), .o_up_valid_in(up_valid_in),
        .i_up_out_en(up_out_en), .o_out_id(out_id), .o_out_id_valid(out_id_valid),
        .o_grant_id(grant_id), .o_busy(busy), .o_tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_src(input int id, input logic [W-1:0] d, input bit expect_beat);
        src_q[id].push_back(d);
        if (expect_beat) exp_beat.push_back('{id: 2'(id), data: d});
    endtask

    task automatic wait_busy(input logic lvl, input string nm);
        int n;
        n = 0;
        while (busy !== lvl && n < 60) begin
            tick();
            n++;
        end
        chk(nm, busy, lvl);
    endtask

    task automatic pulse_out_en(input logic [1:0] id);
        exp_id.push_back(id);
        up_out_en = 1'b1;
        tick();
        up_out_en = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_vin", up_valid_in, 0);
        chk("rst_data", up_inp_data, 0);
        chk("rst_oidv", out_id_valid, 0);
        chk("rst_tagerr", tag_err, 0);
        tick();
        rstn = 1'b1;
    endtask

    // Requester model: pops a beat when it was accepted, then presents the next
    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < NR; i++)
                if (rstn && req_valid[i] && req_ready[i] && src_q[i].size() > 0)
                    src_q[i].delete(0);
            #1;
            for (int i = 0; i < NR; i++) begin
                req_valid[i]         = (src_q[i].size() > 0);
                req_data[i*W +: W]   = (src_q[i].size() > 0) ? src_q[i][0] : '0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (up_valid_in) begin
                if (exp_beat.size() == 0) chk("beat_unexp", up_valid_in, 0);
                else begin
                    beat_t e;
                    e = exp_beat.pop_front();
                    chk("beat_id", grant_id, e.id);
                    chk("beat_data", up_inp_data, e.data);
                    chk("beat_ready", req_ready, 4'b0001 << e.id);
                end
            end
            if (out_id_valid) begin
                if (exp_id.size() == 0) chk("id_unexp", out_id_valid, 0);
                else chk("out_id", out_id, exp_id.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [19:0] obs;
        logic [7:0]  gids;
        logic [2:0]  hold;
        rstn      = 1'b0;
        up_out_en = 1'b0;
        tick();
        do_reset();

        // Single requester
        for (int j = 0; j < 4; j++) push_src(2, W'(8'hA0 + j), 1'b1);
        tick();
        chk("t1_idle_busy", busy, 0);
        tick();
        chk("t1_grant", grant_id, 2);
        chk("t1_busy", busy, 1);
        wait_busy(1'b0, "t1_done");
        pulse_out_en(2'd2);
        tick();
        chk("t1_tagerr", tag_err, 0);

        // Round-robin fairness, then tag FIFO full
        do_reset();
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < 4; j++) push_src(i, W'(8'h10 * (i + 1) + j), 1'b1);
        for (int j = 4; j < 8; j++) push_src(0, W'(8'h10 + j), 1'b1);
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            obs[k] = busy;
            if (k % 5 == 0) gids[2*(k/5) +: 2] = grant_id;
        end
        chk("t2_busy_pattern", obs, 20'b01111011110111101111);
        chk("t2_grants", gids, {2'd3, 2'd2, 2'd1, 2'd0});
        for (int k = 0; k < 3; k++) begin
            tick();
            hold[k] = busy;
        end
        chk("t4_full_hold", hold, 3'b000);
        pulse_out_en(2'd0);
        chk("t4_no_grant_yet", busy, 0);
        tick();
        chk("t4_grant_after_pop", busy, 1);
        chk("t4_grant_id", grant_id, 0);
        for (int i = 1; i < NR; i++) begin
            pulse_out_en(2'(i));
            tick();
        end
        wait_busy(1'b0, "t2_done");
        pulse_out_en(2'd0);
        tick();
        chk("t2_beats_drained", exp_beat.size(), 0);
        chk("t2_ids_drained", exp_id.size(), 0);

        // Mid-burst bubble with a competing requester
        do_reset();
        push_src(1, W'(8'hB0), 1'b1);
        push_src(1, W'(8'hB1), 1'b1);
        for (int j = 0; j < 4; j++) push_src(3, W'(8'hD0 + j), 1'b0);
        tick();
        tick();
        chk("t3_grant", grant_id, 1);
        tick();
        tick();
        chk("t3_gap_vin", up_valid_in, 0);
        chk("t3_gap_ready", req_ready, 4'b0010);
        tick();
        tick();
        chk("t3_gap_grant", grant_id, 1);
        chk("t3_gap_busy", busy, 1);
        push_src(1, W'(8'hB2), 1'b1);
        push_src(1, W'(8'hB3), 1'b1);
        for (int j = 0; j < 4; j++) exp_beat.push_back('{id: 2'd3, data: W'(8'hD0 + j)});
        tick();
        chk("t3_resume_vin", up_valid_in, 1);
        begin
            int n;
            n = 0;
            while (!(busy === 1'b1 && grant_id === 2'd3) && n < 40) begin
                tick();
                n++;
            end
        end
        chk("t3_next_grant", grant_id, 3);
        wait_busy(1'b0, "t3_done");
        pulse_out_en(2'd1);
        pulse_out_en(2'd3);
        tick();
        chk("t3_drained", exp_beat.size() + exp_id.size(), 0);

        // Reset mid-burst: partial burst and its tag are dropped
        do_reset();
        push_src(0, W'(8'hE0), 1'b1);
        push_src(0, W'(8'hE1), 1'b1);
        push_src(0, W'(8'hE2), 1'b0);
        push_src(0, W'(8'hE3), 1'b0);
        tick();
        tick();
        tick();
        tick();
        rstn = 1'b0;
        tick();
        chk("t5_busy", busy, 0);
        chk("t5_vin", up_valid_in, 0);
        chk("t5_ready", req_ready, 0);
        chk("t5_data", up_inp_data, 0);
        chk("t5_partial_seen", exp_beat.size(), 0);
        src_q[0].delete();
        for (int j = 0; j < 4; j++) push_src(0, W'(8'hF0 + j), 1'b1);
        rstn = 1'b1;
        wait_busy(1'b1, "t5_regrant");
        chk("t5_grant", grant_id, 0);
        wait_busy(1'b0, "t5_done");
        pulse_out_en(2'd0);
        tick();
        chk("t5_drained", exp_beat.size() + exp_id.size(), 0);

        // Spurious out_en on an empty FIFO
        up_out_en = 1'b1;
        #1;
        chk("t6_spur_oidv", out_id_valid, 0);
        tick();
        up_out_en = 1'b0;
        chk("t6_tagerr_set", tag_err, 1);
        tick();
        tick();
        tick();
        chk("t6_tagerr_sticky", tag_err, 1);
        do_reset();
        tick();
        chk("t6_tagerr_clear", tag_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
